// File: rtl/sseg_mux_if.sv
// User-side bundle for the seven-segment scan driver: display data, the
// update handshake and the frame pulse.
interface sseg_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] hex_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic                    upd_req;
    logic                    upd_ack;
    logic                    frame_tick;

    modport master (
        output hex_in, dp_in, blank_in, lz_en, upd_req,
        input  upd_ack, frame_tick
    );

    modport slave (
        input  hex_in, dp_in, blank_in, lz_en, upd_req,
        output upd_ack, frame_tick
    );
endinterface

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// shadow loading, anti-ghosting guard interval and leading-zero suppression.
module sseg_mux_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sseg_mux_if.slave             bus,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            sseg,
    output logic                  dp
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    pend;
    logic [4*NUM_DIGITS-1:0] sh_hex;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_lz;

    logic                    digit_end;
    logic                    frame_end;
    logic                    load;
    logic                    in_guard;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              sseg_next;
    logic                    dp_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign digit_end = (cnt == CNT_LAST);
    assign frame_end = digit_end && (idx == IDX_LAST);
    // A request arriving in the boundary cycle itself is honoured immediately.
    assign load      = frame_end && (pend || bus.upd_req);

    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD_CYCLES));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (digit_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend           <= 1'b0;
            sh_hex         <= '0;
            sh_dp          <= '0;
            sh_blank       <= '1;
            sh_lz          <= 1'b0;
            bus.upd_ack    <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.frame_tick <= frame_end;
            bus.upd_ack    <= load;
            if (load) begin
                sh_hex   <= bus.hex_in;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank_in;
                sh_lz    <= bus.lz_en;
                pend     <= 1'b0;
            end else if (bus.upd_req) begin
                pend     <= 1'b1;
            end
        end
    end

    // A digit is zero-suppressed only when it and every more significant digit are zero.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        lz_blank  = sh_lz && (idx != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx == IW'(j)) begin
                cur_nib   = sh_hex[4*j +: 4];
                cur_dp    = sh_dp[j];
                cur_blank = sh_blank[j];
            end
            if ((IW'(j) >= idx) && (sh_hex[4*j +: 4] != 4'h0)) begin
                lz_blank = 1'b0;
            end
        end
        an_next   = ~(NUM_DIGITS'(1) << idx);
        sseg_next = (cur_blank || lz_blank) ? 7'h7F : decode(cur_nib);
        dp_next   = ~(cur_dp & ~cur_blank);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an   <= '1;
            sseg <= 7'h7F;
            dp   <= 1'b1;
        end else if (in_guard) begin
            an   <= '1;
            sseg <= 7'h7F;
            dp   <= 1'b1;
        end else begin
            an   <= an_next;
            sseg <= sseg_next;
            dp   <= dp_next;
        end
    end
endmodule

// File: tb/tb_sseg_mux_driver.sv
// Randomised bench for sseg_mux_driver: a cycle-count based reference model
// checks a guarded and an unguarded instance every cycle.
module tb_sseg_mux_driver;
    localparam int ND = 4;
    localparam int DC = 8;
    localparam int GC = 2;
    localparam int FRAME = DC * ND;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          checking = 1'b0;
    logic [ND-1:0] an, an0;
    logic [6:0]    sseg, sseg0;
    logic          dp, dp0;
    int            checks = 0;
    int            passes = 0;

    sseg_mux_if #(.NUM_DIGITS(ND)) bus ();
    sseg_mux_if #(.NUM_DIGITS(ND)) bus0 ();

    assign bus0.hex_in   = bus.hex_in;
    assign bus0.dp_in    = bus.dp_in;
    assign bus0.blank_in = bus.blank_in;
    assign bus0.lz_en    = bus.lz_en;
    assign bus0.upd_req  = bus.upd_req;

    sseg_mux_driver #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .GUARD_CYCLES(GC)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .an(an), .sseg(sseg), .dp(dp)
    );

    sseg_mux_driver #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .GUARD_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .an(an0), .sseg(sseg0), .dp(dp0)
    );

    always #5 clk = ~clk;

    // Reference model: position in the scan follows from the edge count since reset.
    int            cyc;
    logic          m_pend;
    logic [15:0]   m_hex;
    logic [3:0]    m_dp, m_blank;
    logic          m_lz;
    logic [ND-1:0] exp_an, exp_an0;
    logic [6:0]    exp_sseg, exp_sseg0;
    logic          exp_dp, exp_dp0, exp_ack, exp_tick;

    function automatic int digit_of(input int k);
        return (k / DC) % ND;
    endfunction

    function automatic logic at_frame_end(input int k);
        return (k % FRAME) == FRAME - 1;
    endfunction

    function automatic logic [6:0] model_seg(input int d);
        if (m_blank[d]) return 7'h7F;
        if (m_lz && d != 0 && (m_hex >> (4 * d)) == 16'h0) return 7'h7F;
        return SEG_TABLE[m_hex[4*d +: 4]];
    endfunction

    function automatic logic model_dp(input int d);
        return ~(m_dp[d] & ~m_blank[d]);
    endfunction

    function automatic logic [ND-1:0] anode_of(input int d);
        return ~(ND'(1) << d);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= 0; m_pend <= 1'b0;
            m_hex <= '0; m_dp <= '0; m_blank <= '1; m_lz <= 1'b0;
            exp_an <= '1; exp_sseg <= 7'h7F; exp_dp <= 1'b1;
            exp_an0 <= '1; exp_sseg0 <= 7'h7F; exp_dp0 <= 1'b1;
            exp_ack <= 1'b0; exp_tick <= 1'b0;
        end else begin
            exp_tick <= at_frame_end(cyc);
            exp_ack  <= at_frame_end(cyc) && (m_pend || bus.upd_req);
            if (cyc % DC < GC) begin
                exp_an <= '1; exp_sseg <= 7'h7F; exp_dp <= 1'b1;
            end else begin
                exp_an   <= anode_of(digit_of(cyc));
                exp_sseg <= model_seg(digit_of(cyc));
                exp_dp   <= model_dp(digit_of(cyc));
            end
            exp_an0   <= anode_of(digit_of(cyc));
            exp_sseg0 <= model_seg(digit_of(cyc));
            exp_dp0   <= model_dp(digit_of(cyc));
            if (at_frame_end(cyc) && (m_pend || bus.upd_req)) begin
                m_hex <= bus.hex_in; m_dp <= bus.dp_in;
                m_blank <= bus.blank_in; m_lz <= bus.lz_en;
                m_pend <= 1'b0;
            end else if (bus.upd_req) begin
                m_pend <= 1'b1;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want)
            $display("[TB] FAIL %s at %0t: got %h want %h", name, $time, got, want);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_output("scan_g2", 32'({an, sseg, dp, bus.upd_ack, bus.frame_tick}),
                         32'({exp_an, exp_sseg, exp_dp, exp_ack, exp_tick}));
            check_output("scan_g0", 32'({an0, sseg0, dp0, bus0.upd_ack, bus0.frame_tick}),
                         32'({exp_an0, exp_sseg0, exp_dp0, exp_ack, exp_tick}));
        end
    end

    // Drives a new display word with an upd_req pulse and waits for the ack;
    // second_at > 0 re-pulses upd_req that many cycles later while pending.
    task automatic apply_stimulus(input logic [15:0] hex, input logic [3:0] dpv,
                                  input logic [3:0] blank, input logic lz,
                                  input int second_at, output int waited);
        bus.hex_in = hex; bus.dp_in = dpv; bus.blank_in = blank; bus.lz_en = lz;
        bus.upd_req = 1'b1;
        waited = 0;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            @(negedge clk);
            if (bus.upd_ack) begin
                waited = i;
                break;
            end
            bus.upd_req = (i == second_at);
        end
        bus.upd_req = 1'b0;
        check_output("ack_seen", 32'(waited > 0), 32'd1);
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while ((cyc % FRAME) != p && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_output("phase_reached", 32'((cyc % FRAME) == p), 32'd1);
    endtask

    // Hand-computed expectations for one whole frame after an acknowledged load.
    task automatic check_lit_frame(input string name, input logic [27:0] segs, input logic [3:0] dps);
        logic [ND-1:0] an_want;
        for (int d = 0; d < ND; d++) begin
            an_want = ~(ND'(1) << d);
            for (int s = 0; s < DC; s++) begin
                @(negedge clk);
                if (s < GC)
                    check_output(name, 32'({an, sseg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
                else
                    check_output(name, 32'({an, sseg, dp}), 32'({an_want, segs[7*d +: 7], dps[d]}));
                check_output({name, "_g0"}, 32'(an0), 32'(an_want));
            end
        end
    endtask

    initial begin
        int waited, ticks, acks, lit;
        logic [15:0] hex_r;

        bus.hex_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.lz_en = 1'b0; bus.upd_req = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        reset_n = 1'b1;

        // Idle after reset: frame ticks, no acks, segments dark.
        ticks = 0; acks = 0; lit = 0;
        repeat (64) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
            if (bus.upd_ack) acks++;
            if (sseg != 7'h7F || dp != 1'b1) lit++;
        end
        check_output("idle_ticks", 32'(ticks), 32'd2);
        check_output("idle_acks", 32'(acks), 32'd0);
        check_output("idle_dark", 32'(lit), 32'd0);

        $display("[TB] basic load");
        apply_stimulus(16'h1A3F, 4'b0100, 4'b0000, 1'b0, 0, waited);
        check_lit_frame("frame_1A3F", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1011);

        $display("[TB] leading zero suppression");
        apply_stimulus(16'h0050, 4'b0000, 4'b0000, 1'b1, 0, waited);
        check_lit_frame("frame_lz", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);

        $display("[TB] blank mask");
        apply_stimulus(16'h1234, 4'hF, 4'b0010, 1'b0, 0, waited);
        check_lit_frame("frame_blank", {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b0010);

        $display("[TB] request in boundary cycle");
        wait_phase(FRAME - 1);
        apply_stimulus(16'hBEEF, 4'b1001, 4'b0000, 1'b0, 0, waited);
        check_output("boundary_latency", 32'(waited), 32'd1);

        $display("[TB] double request while pending");
        wait_phase(3);
        apply_stimulus(16'hC0DE, 4'b0011, 4'b0100, 1'b1, 6, waited);
        acks = 0;
        repeat (FRAME + 8) begin
            @(negedge clk);
            if (bus.upd_ack) acks++;
        end
        check_output("single_ack", 32'(acks), 32'd0);

        $display("[TB] randomised loads");
        for (int n = 0; n < 12; n++) begin
            hex_r = 16'($urandom);
            hex_r = hex_r >> (4 * $urandom_range(0, 4));
            apply_stimulus(hex_r, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                           1'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0,
                           waited);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        $display("[TB] reset mid-scan with pending request");
        wait_phase(4);
        bus.upd_req = 1'b1;
        @(negedge clk);
        bus.upd_req = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_reset_g2", 32'({an, sseg, dp, bus.upd_ack, bus.frame_tick}),
                     32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        check_output("async_reset_g0", 32'({an0, sseg0, dp0, bus0.upd_ack, bus0.frame_tick}),
                     32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        acks = 0; lit = 0;
        repeat (FRAME * 2 + 6) begin
            @(negedge clk);
            if (bus.upd_ack) acks++;
            if (sseg != 7'h7F || dp != 1'b1 || sseg0 != 7'h7F || dp0 != 1'b1) lit++;
        end
        check_output("post_reset_acks", 32'(acks), 32'd0);
        check_output("post_reset_dark", 32'(lit), 32'd0);

        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
